// File: rtl/dma_snd_fifo_reader_if.sv
// Bus between the DMA fetch sequencer / sample consumer and the sound FIFO reader.
// master drives words, strobes and mode; slave is the FIFO reader itself.
interface dma_snd_fifo_reader_if #(
    parameter int AW = 2
);
    logic          flush;
    logic          stereo;
    logic          wr;
    logic [15:0]   wdata;
    logic          tick;
    logic          req;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic [7:0]    left;
    logic [7:0]    right;
    logic          smp_stb;
    logic          underrun;
    logic          overflow;

    modport master (
        output flush, stereo, wr, wdata, tick,
        input  req, full, empty, level, left, right, smp_stb, underrun, overflow
    );

    modport slave (
        input  flush, stereo, wr, wdata, tick,
        output req, full, empty, level, left, right, smp_stb, underrun, overflow
    );
endinterface

// File: rtl/dma_snd_fifo_reader.sv
// Sound DMA consumer: buffers 16-bit sample words and emits signed 8-bit L/R samples
// on each sample-rate tick, in mono (two samples per word) or stereo (one pair per word).
module dma_snd_fifo_reader #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int REQ_LVL = 2
) (
    input  logic                     c,
    input  logic                     xr,
    dma_snd_fifo_reader_if.slave     bus
);
    typedef enum logic {PH_HI, PH_LO} phase_e;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   level_q, level_d;
    phase_e        phase_q, phase_d;
    logic          stereo_q;
    logic [7:0]    left_q, left_d, right_q, right_d;
    logic          stb_q, stb_d, undr_q, undr_d, ovf_q, ovf_d;

    logic          empty, full, pop, push;
    logic [15:0]   head;

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // A word is only consumed after its second byte in mono; stereo consumes whole words.
    assign pop  = bus.tick && !empty && !bus.flush && (bus.stereo || phase_q == PH_LO);
    assign push = bus.wr && !bus.flush && (!full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        phase_d  = phase_q;
        left_d   = left_q;
        right_d  = right_q;
        stb_d    = 1'b0;
        undr_d   = 1'b0;
        ovf_d    = ovf_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            phase_d  = PH_HI;
            left_d   = '0;
            right_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      level_d = level_q + (AW+1)'(1);
            else if (pop && !push) level_d = level_q - (AW+1)'(1);
            if (bus.wr && !push) ovf_d = 1'b1;

            // Mode change mid-word restarts the head word from its high byte.
            if (bus.stereo != stereo_q) phase_d = PH_HI;

            if (bus.tick) begin
                if (empty) begin
                    left_d  = '0;
                    right_d = '0;
                    undr_d  = 1'b1;
                    phase_d = PH_HI;
                end else begin
                    stb_d = 1'b1;
                    if (bus.stereo) begin
                        left_d  = head[15:8];
                        right_d = head[7:0];
                        phase_d = PH_HI;
                    end else if (phase_q == PH_HI) begin
                        left_d  = head[15:8];
                        right_d = head[15:8];
                        phase_d = PH_LO;
                    end else begin
                        left_d  = head[7:0];
                        right_d = head[7:0];
                        phase_d = PH_HI;
                    end
                end
            end
        end
    end

    always_ff @(posedge c or negedge xr) begin
        if (!xr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            phase_q  <= PH_HI;
            stereo_q <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
            stb_q    <= 1'b0;
            undr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
            stereo_q <= bus.stereo;
            left_q   <= left_d;
            right_q  <= right_d;
            stb_q    <= stb_d;
            undr_q   <= undr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge c) begin
        if (push) mem_q[wr_ptr_q] <= bus.wdata;
    end

    assign bus.req      = (level_q <= (AW+1)'(REQ_LVL)) && !bus.flush;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level_q;
    assign bus.left     = left_q;
    assign bus.right    = right_q;
    assign bus.smp_stb  = stb_q;
    assign bus.underrun = undr_q;
    assign bus.overflow = ovf_q;
endmodule
